// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared mode encoding and default timing constants for clock_ctrl
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2,
    MODE_SET_S = 2'd3
  } mode_t;

  localparam int DEF_CLK_HZ       = 50_000_000;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_BLINK_HALF   = 12_500_000;

  // K0 walks RUN -> SET_H -> SET_M -> SET_S -> RUN; the 2-bit encoding wraps naturally.
  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(2'(m + 2'd1));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchronizer, level debouncer and press-event generator for one active-low key
module key_debounce
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic [1:0]    fill;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          settle;

  assign differ = (sync2 != level);
  assign settle = differ && (cnt == CW'(DEBOUNCE_CYC - 1));

  // Press events stay disarmed until a genuine released level is seen after
  // reset, so a key held through reset release cannot fire.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && sync2 && level) begin
        armed <= 1'b1;
      end
      press <= settle && level && armed;
      if (settle) begin
        level <= ~level;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - digital-clock sequencer: 1 Hz tick, key conditioning, RUN/SET mode FSM,
// counter command pulses with carry cascade, and blinking blank masks.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       K0,
  input  logic       K1,
  input  logic       K2,
  input  logic       K3,
  input  logic       sec_at_max,
  input  logic       min_at_max,
  input  logic       hour_at_max,
  output logic       sec_inc,
  output logic       sec_dec,
  output logic       min_inc,
  output logic       min_dec,
  output logic       hour_inc,
  output logic       hour_dec,
  output logic       sec_clr,
  output logic       tick,
  output logic       blank_s,
  output logic       blank_m,
  output logic       blank_h,
  output logic [1:0] mode
);

  localparam int DIV_W = $clog2(CLK_HZ + 1);
  localparam int BLK_W = $clog2(BLINK_HALF + 1);

  logic [3:0] raw;
  logic [3:0] key_level;
  logic [3:0] key_press;

  assign raw = {K3, K2, K1, K0};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .key     (raw[i]),
      .level   (key_level[i]),
      .press   (key_press[i])
    );
  end

  // Hours carry-out and the debounced levels are not needed by the sequencer.
  logic unused_ok;
  assign unused_ok = ^{hour_at_max, key_level};

  mode_t            mode_q, mode_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [BLK_W-1:0] blink_q, blink_n;
  logic             blink_on_q, blink_on_n;
  logic             k_up, k_dn;
  logic             tick_n, sec_inc_n, sec_dec_n, min_inc_n, min_dec_n;
  logic             hour_inc_n, hour_dec_n, sec_clr_n;
  logic             blank_s_n, blank_m_n, blank_h_n;

  // Up/down only count when they are the sole key event of the cycle.
  assign k_up = key_press[1] && !key_press[2] && !key_press[0];
  assign k_dn = key_press[2] && !key_press[1] && !key_press[0];

  always_comb begin
    mode_n     = mode_q;
    div_n      = div_q;
    blink_n    = blink_q;
    blink_on_n = blink_on_q;
    tick_n     = 1'b0;
    sec_inc_n  = 1'b0;
    sec_dec_n  = 1'b0;
    min_inc_n  = 1'b0;
    min_dec_n  = 1'b0;
    hour_inc_n = 1'b0;
    hour_dec_n = 1'b0;
    sec_clr_n  = 1'b0;

    if (mode_q == MODE_RUN) begin
      if (div_q == DIV_W'(CLK_HZ - 1)) begin
        div_n      = '0;
        tick_n     = 1'b1;
        sec_inc_n  = 1'b1;
        min_inc_n  = sec_at_max;
        hour_inc_n = sec_at_max && min_at_max;
      end else begin
        div_n = div_q + DIV_W'(1);
      end
    end else begin
      div_n = '0;
      if (blink_q == BLK_W'(BLINK_HALF - 1)) begin
        blink_n    = '0;
        blink_on_n = !blink_on_q;
      end else begin
        blink_n = blink_q + BLK_W'(1);
      end
      case (mode_q)
        MODE_SET_H: begin
          hour_inc_n = k_up;
          hour_dec_n = k_dn;
        end
        MODE_SET_M: begin
          min_inc_n = k_up;
          min_dec_n = k_dn;
        end
        MODE_SET_S: begin
          sec_inc_n = k_up;
          sec_dec_n = k_dn;
        end
        default: begin
        end
      endcase
    end

    if (key_press[0]) begin
      mode_n     = next_mode(mode_q);
      blink_n    = '0;
      blink_on_n = 1'b0;
      div_n      = '0;
    end

    // Clear overrides a coincident tick: the second restarts from zero.
    if (key_press[3]) begin
      sec_clr_n  = 1'b1;
      div_n      = '0;
      tick_n     = 1'b0;
      sec_inc_n  = 1'b0;
      min_inc_n  = 1'b0;
      hour_inc_n = 1'b0;
    end

    blank_h_n = (mode_n == MODE_SET_H) && blink_on_n;
    blank_m_n = (mode_n == MODE_SET_M) && blink_on_n;
    blank_s_n = (mode_n == MODE_SET_S) && blink_on_n;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      mode_q     <= MODE_RUN;
      div_q      <= '0;
      blink_q    <= '0;
      blink_on_q <= 1'b0;
      tick       <= 1'b0;
      sec_inc    <= 1'b0;
      sec_dec    <= 1'b0;
      min_inc    <= 1'b0;
      min_dec    <= 1'b0;
      hour_inc   <= 1'b0;
      hour_dec   <= 1'b0;
      sec_clr    <= 1'b0;
      blank_s    <= 1'b0;
      blank_m    <= 1'b0;
      blank_h    <= 1'b0;
    end else begin
      mode_q     <= mode_n;
      div_q      <= div_n;
      blink_q    <= blink_n;
      blink_on_q <= blink_on_n;
      tick       <= tick_n;
      sec_inc    <= sec_inc_n;
      sec_dec    <= sec_dec_n;
      min_inc    <= min_inc_n;
      min_dec    <= min_dec_n;
      hour_inc   <= hour_inc_n;
      hour_dec   <= hour_dec_n;
      sec_clr    <= sec_clr_n;
      blank_s    <= blank_s_n;
      blank_m    <= blank_m_n;
      blank_h    <= blank_h_n;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - scoreboard bench for clock_ctrl: expected pulses and mode changes queued at stimulus time
module tb_clock_ctrl;
  import clock_ctrl_pkg::*;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int BH     = 3;
  localparam int LAT    = DEB + 3;

  localparam logic [7:0] P_TICK = 8'h80;
  localparam logic [7:0] P_SINC = 8'h40;
  localparam logic [7:0] P_SDEC = 8'h20;
  localparam logic [7:0] P_MINC = 8'h10;
  localparam logic [7:0] P_MDEC = 8'h08;
  localparam logic [7:0] P_HINC = 8'h04;
  localparam logic [7:0] P_HDEC = 8'h02;
  localparam logic [7:0] P_SCLR = 8'h01;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keys = 4'hF;
  logic       sec_max = 1'b0, min_max = 1'b0, hour_max = 1'b0;
  logic       sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec, sec_clr, tick;
  logic       blank_s, blank_m, blank_h;
  logic [1:0] mode;
  logic [7:0] pvec;

  assign pvec = {tick, sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec, sec_clr};

  clock_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_CYC(DEB),
    .BLINK_HALF  (BH)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .K0         (keys[0]),
    .K1         (keys[1]),
    .K2         (keys[2]),
    .K3         (keys[3]),
    .sec_at_max (sec_max),
    .min_at_max (min_max),
    .hour_at_max(hour_max),
    .sec_inc    (sec_inc),
    .sec_dec    (sec_dec),
    .min_inc    (min_inc),
    .min_dec    (min_dec),
    .hour_inc   (hour_inc),
    .hour_dec   (hour_dec),
    .sec_clr    (sec_clr),
    .tick       (tick),
    .blank_s    (blank_s),
    .blank_m    (blank_m),
    .blank_h    (blank_h),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
    string      tag;
  } pev_t;

  typedef struct {
    int         cyc;
    logic [1:0] m;
  } mev_t;

  pev_t       sb[$];
  mev_t       mq[$];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         mon_en = 1'b0;
  logic [1:0] exp_mode = 2'd0;
  int         entry = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic monitor();
    logic [2:0] eb;
    pev_t       e;
    int         idx;
    if (mq.size() > 0 && mq[0].cyc <= cyc) begin
      exp_mode = mq[0].m;
      entry    = cyc;
      void'(mq.pop_front());
    end
    check("mode", 32'(mode), 32'(exp_mode));
    eb = 3'b000;
    if (exp_mode != 2'd0 && ((cyc - entry) / BH) % 2 == 1) begin
      idx     = 3 - int'(exp_mode);
      eb[idx] = 1'b1;
    end
    check("blank_hms", 32'({blank_h, blank_m, blank_s}), 32'(eb));
    if (pvec != 8'h00 || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", 32'(pvec), 0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_cyc"}, cyc, e.cyc);
        check(e.tag, 32'(pvec), 32'(e.vec));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) monitor();
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    check("sb_drained", sb.size(), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    mq.push_back('{cyc: cyc + 1, m: 2'd0});
    #1;
    check("rst_mode", 32'(mode), 0);
    check("rst_blank", 32'({blank_h, blank_m, blank_s}), 0);
    check("rst_pulse", 32'(pvec), 0);
    step(3);
    reset = 1'b1;
  endtask

  task automatic hit(input logic [3:0] mask, input int hold, input logic [7:0] vec,
                     input int nm, input string tag);
    int n;
    n    = cyc;
    keys = keys & ~mask;
    if (vec != 8'h00) sb.push_back('{cyc: n + LAT, vec: vec, tag: tag});
    if (nm >= 0) mq.push_back('{cyc: n + LAT, m: 2'(nm)});
    step(hold);
    keys = keys | mask;
    step(9);
  endtask

  initial begin
    int b;
    int n;
    step(1);

    // RUN tick with full, partial and no carry
    sec_max  = 1'b1;
    min_max  = 1'b1;
    hour_max = 1'b1;
    do_reset();
    b = cyc;
    for (int i = 1; i <= 3; i++)
      sb.push_back('{cyc: b + 10 * i, vec: P_TICK | P_SINC | P_MINC | P_HINC, tag: "tick_carry2"});
    sb.push_back('{cyc: b + 40, vec: P_TICK | P_SINC | P_MINC, tag: "tick_carry1"});
    sb.push_back('{cyc: b + 50, vec: P_TICK | P_SINC, tag: "tick_plain"});
    step(35);
    min_max = 1'b0;
    step(10);
    sec_max = 1'b0;
    step(10);

    // Debounce latency, glitch rejection, SET modes and key conflicts
    do_reset();
    b = cyc;
    step(2);
    hit(4'b0001, 20, 8'h00, 1, "k0_adv");
    check("single_adv", 32'(mode), 1);
    hit(4'b0010, 3, 8'h00, -1, "k1_glitch");
    hit(4'b0010, 8, P_HINC, -1, "h_inc");
    hit(4'b0100, 8, P_HDEC, -1, "h_dec");
    hit(4'b0011, 8, 8'h00, 2, "k0_k1");
    hit(4'b0010, 8, P_MINC, -1, "m_inc");
    hit(4'b0100, 8, P_MDEC, -1, "m_dec");
    hit(4'b0110, 8, 8'h00, -1, "k1_k2");
    hit(4'b1000, 8, P_SCLR, -1, "clr_set");
    hit(4'b0001, 8, 8'h00, 3, "k0_to_s");
    hit(4'b0010, 8, P_SINC, -1, "s_inc");
    hit(4'b0100, 8, P_SDEC, -1, "s_dec");

    // Back to RUN; K3 lands on the first tick cycle
    sec_max = 1'b1;
    min_max = 1'b1;
    n = cyc;
    keys[0] = 1'b0;
    mq.push_back('{cyc: n + LAT, m: 2'd0});
    step(10);
    keys[3] = 1'b0;
    sb.push_back('{cyc: n + 17, vec: P_SCLR, tag: "clr_vs_tick"});
    step(8);
    keys = 4'hF;
    sb.push_back('{cyc: n + 27, vec: P_TICK | P_SINC | P_MINC | P_HINC, tag: "tick_after_clr"});
    sb.push_back('{cyc: n + 37, vec: P_TICK | P_SINC | P_MINC | P_HINC, tag: "tick_period"});
    step(21);

    // Async reset in SET_S with K2 (and K0) held through reset release
    do_reset();
    step(2);
    hit(4'b0001, 8, 8'h00, 1, "to_h");
    hit(4'b0001, 8, 8'h00, 2, "to_m");
    hit(4'b0001, 8, 8'h00, 3, "to_s");
    n = cyc;
    keys[2] = 1'b0;
    sb.push_back('{cyc: n + LAT, vec: P_SDEC, tag: "s_dec_held"});
    step(12);
    keys[0] = 1'b0;
    do_reset();
    step(9);
    check("held_no_adv", 32'(mode), 0);
    keys = 4'hF;
    do_reset();
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
